// File: rtl/animation_recorder.sv
// -----------------------------------------------------------------------------
// animation_recorder
//
// Purpose:
//   Writer side of the LED animation path. The user composes WIDTH-bit frames
//   with debounced push buttons, appends them to an on-chip frame RAM, and
//   replays the stored frames on the LED header at the animation tick rate.
//
// Ports:
//   CLK          in   system clock
//   RST_N        in   asynchronous active-low reset
//   ani_tick     in   one-cycle enable pulse at frame rate
//   btn_cursor   in   debounced level, advance edit cursor
//   btn_toggle   in   debounced level, flip bit under cursor
//   btn_save     in   debounced level, append edit buffer to RAM
//   btn_clear    in   debounced level, erase recording
//   btn_mode     in   debounced level, toggle EDIT/PLAY
//   leds         out  LED drive, bit WIDTH-1 = leftmost
//   cursor       out  current edit bit index
//   frame_count  out  number of stored frames
//   playing      out  1 while in PLAY
//   full         out  frame_count == DEPTH
//
// Optional feature:
//   ANIMATION_RECORDER_CURSOR_BLINK_EN - when defined, the bit under the cursor
//   blinks in EDIT (inverted on every other ani_tick).
// -----------------------------------------------------------------------------
module animation_recorder #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 20,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ani_tick,
    input  logic              btn_cursor,
    input  logic              btn_toggle,
    input  logic              btn_save,
    input  logic              btn_clear,
    input  logic              btn_mode,
    output logic [WIDTH-1:0]  leds,
    output logic [ADDR_W-1:0] cursor,
    output logic [ADDR_W-1:0] frame_count,
    output logic              playing,
    output logic              full
);

    localparam logic [ADDR_W-1:0] LP_DEPTH    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST_BIT = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LP_ONE      = ADDR_W'(1);

    typedef enum logic {
        S_EDIT = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         w_btn;
    logic [4:0]         r_sync1;
    logic [4:0]         r_sync2;
    logic [4:0]         r_sync3;
    logic [4:0]         w_ev;
    logic               w_ev_clr;
    logic               w_ev_mode;
    logic               w_ev_save;
    logic               w_ev_tog;
    logic               w_ev_cur;

    logic [WIDTH-1:0]   r_buf;
    logic [WIDTH-1:0]   w_buf_nxt;
    logic [ADDR_W-1:0]  r_cursor;
    logic [ADDR_W-1:0]  w_cursor_nxt;
    logic [ADDR_W-1:0]  r_count;
    logic [ADDR_W-1:0]  w_count_nxt;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  w_rd_ptr_nxt;
    logic               w_we;

    logic [WIDTH-1:0]   r_ram [0:DEPTH-1];
    logic [WIDTH-1:0]   r_rd_data;
    logic [WIDTH-1:0]   r_leds;
    logic [WIDTH-1:0]   w_blink_mask;
    logic               r_playing;
    logic               r_full;

    // Bit order inside the event vector sets the priority: higher index wins.
    assign w_btn = {btn_clear, btn_mode, btn_save, btn_toggle, btn_cursor};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Rising edge of the synchronized level; a held button yields one event.
    assign w_ev      = r_sync2 & ~r_sync3;
    assign w_ev_clr  = w_ev[4];
    assign w_ev_mode = w_ev[3] & ~w_ev[4];
    assign w_ev_save = w_ev[2] & ~(|w_ev[4:3]);
    assign w_ev_tog  = w_ev[1] & ~(|w_ev[4:2]);
    assign w_ev_cur  = w_ev[0] & ~(|w_ev[4:1]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_EDIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_cursor_nxt = r_cursor;
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        w_we         = 1'b0;
        case (r_state)
            S_EDIT: begin
                if (w_ev_clr) begin
                    w_buf_nxt    = '0;
                    w_cursor_nxt = '0;
                    w_count_nxt  = '0;
                end else if (w_ev_mode) begin
                    if (r_count != '0) begin
                        w_state_nxt  = S_PLAY;
                        w_rd_ptr_nxt = '0;
                    end
                end else if (w_ev_save) begin
                    if (r_count < LP_DEPTH) begin
                        w_we        = 1'b1;
                        w_count_nxt = r_count + LP_ONE;
                    end
                end else if (w_ev_tog) begin
                    w_buf_nxt = r_buf ^ (WIDTH'(1) << r_cursor);
                end else if (w_ev_cur) begin
                    w_cursor_nxt = (r_cursor == LP_LAST_BIT) ? '0 : r_cursor + LP_ONE;
                end
            end
            S_PLAY: begin
                if (w_ev_clr) begin
                    w_state_nxt  = S_EDIT;
                    w_buf_nxt    = '0;
                    w_cursor_nxt = '0;
                    w_count_nxt  = '0;
                end else if (w_ev_mode) begin
                    w_state_nxt = S_EDIT;
                end else if (ani_tick) begin
                    w_rd_ptr_nxt = (r_rd_ptr == r_count - LP_ONE) ? '0 : r_rd_ptr + LP_ONE;
                end
            end
            default: w_state_nxt = S_EDIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_buf     <= '0;
            r_cursor  <= '0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_playing <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_buf     <= w_buf_nxt;
            r_cursor  <= w_cursor_nxt;
            r_count   <= w_count_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            // Flags follow the next state so they line up with state/count.
            r_playing <= (w_state_nxt == S_PLAY);
            r_full    <= (w_count_nxt == LP_DEPTH);
        end
    end

    // Frame RAM. Read address is the next pointer so the read data is aligned
    // with r_rd_ptr, and the first frame is ready the cycle after PLAY entry.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_ram[r_count] <= r_buf;
        end
        r_rd_data <= r_ram[w_rd_ptr_nxt];
    end

`ifdef ANIMATION_RECORDER_CURSOR_BLINK_EN
    logic r_blink;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_blink <= 1'b0;
        end else if (r_state == S_PLAY && w_state_nxt == S_EDIT) begin
            r_blink <= 1'b0;
        end else if (ani_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_blink_mask = r_blink ? (WIDTH'(1) << r_cursor) : '0;
`else
    assign w_blink_mask = '0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_leds <= '0;
        end else if (r_state == S_PLAY) begin
            r_leds <= r_rd_data;
        end else begin
            r_leds <= r_buf ^ w_blink_mask;
        end
    end

    assign leds        = r_leds;
    assign cursor      = r_cursor;
    assign frame_count = r_count;
    assign playing     = r_playing;
    assign full        = r_full;

endmodule

// File: doc/animation_recorder.md
Name: animation_recorder

Overview:
- Writer side of the LED animation path. The user composes WIDTH-bit frames with push buttons and stores them in an on-chip frame RAM.
- The block replays the stored frames on the LED header at the animation tick rate.
- It sits between the debounced button outputs and the header LEDs. The clock divider supplies ani_tick.

Parameters:
- WIDTH, 10, bits per frame (one per header LED).
- DEPTH, 20, maximum stored frames; must satisfy DEPTH < 2**ADDR_W.
- ADDR_W, 5, width of frame address and frame_count.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST_N  in  1  asynchronous active-low reset.
- ani_tick  in  1  one-CLK-cycle enable pulse at frame rate.
- btn_cursor  in  1  debounced level; advance edit cursor.
- btn_toggle  in  1  debounced level; flip bit under cursor.
- btn_save  in  1  debounced level; append edit buffer to RAM.
- btn_clear  in  1  debounced level; erase recording.
- btn_mode  in  1  debounced level; toggle EDIT/PLAY.
- leds  out  WIDTH  LED drive, bit WIDTH-1 = leftmost.
- cursor  out  ADDR_W  current edit bit index.
- frame_count  out  ADDR_W  frames stored.
- playing  out  1  1 in PLAY.
- full  out  1  frame_count == DEPTH.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low. Every flop except the frame RAM resets.
- Reset values:
  - state = EDIT; edit buffer = 0; cursor = 0; frame_count = 0; rd_ptr = 0.
  - leds = 0; playing = 0; full = 0.
  - Button sync/edge registers = 0.
  - RAM contents are not reset and are never visible while frame_count = 0.
- Buttons:
  - Each btn_* passes through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle event.
  - A held button produces exactly one event.
  - Event latency: 3 CLK cycles from input rise.
- Event priority, when several events land in the same cycle: clear > mode > save > toggle > cursor. Only the highest-priority event acts; the others are dropped.
- EDIT state:
  - cursor event: cursor = (cursor == WIDTH-1) ? 0 : cursor+1.
  - toggle event: buf[cursor] ^= 1.
  - save event:
    - If frame_count < DEPTH: RAM[frame_count] = buf, then frame_count += 1. buf and cursor are unchanged.
    - If full: no write and no count change.
  - clear event: frame_count = 0, buf = 0, cursor = 0.
  - mode event:
    - If frame_count > 0: go to PLAY with rd_ptr = 0.
    - Else: stay in EDIT, no effect.
  - leds = buf, registered. leds update on the cycle after the event.
- PLAY state:
  - RAM is read synchronously (BRAM-inferable).
  - leds = RAM[rd_ptr], registered. leds show a new frame within 2 CLK cycles of rd_ptr changing or of entering PLAY.
  - ani_tick: rd_ptr = (rd_ptr == frame_count-1) ? 0 : rd_ptr+1. With frame_count = 1, leds stay constant.
  - mode event: return to EDIT. buf and cursor are preserved, and leds = buf next cycle.
  - clear event: frame_count = 0, buf = 0, cursor = 0, and go to EDIT.
  - toggle, cursor and save events are ignored in PLAY.
- Flags: full and playing are registered and consistent with the state/count in the same cycle.
- Reset mid-operation: if RST_N asserts during a save or during playback, all state returns to reset values immediately. A partially written frame is discarded because frame_count = 0.

Optional Feature:
- Macro: ANIMATION_RECORDER_CURSOR_BLINK_EN.
- Defined:
  - In EDIT, leds[cursor] = buf[cursor] ^ blink. blink is a flop that toggles on every ani_tick and is cleared on reset and on entry to EDIT.
  - All other bits = buf. In PLAY, blink has no effect.
- Undefined: no blink flop; leds = buf exactly in EDIT.

Test Plan:
- Reset, then 3 cursor pulses, toggle, cursor, toggle -> cursor = 4, leds = 10'b0000011000 (bits 3 and 4 set), frame_count = 0.
- Save three frames 10'h001, 10'h002, 10'h004, then mode, then 7 ani_tick pulses -> playing = 1, leds sequence 001,002,004,001,002,004,001,002 (wrap at count-1).
- Save 21 times -> frame_count = 20, full = 1; the 21st save is ignored and the RAM at index 19 is unchanged on playback.
- Mode with frame_count = 0 -> playing stays 0, leds = buf. clear and mode asserted in the same cycle while in PLAY -> state = EDIT, frame_count = 0, leds = 0.
- Hold btn_toggle high for 1000 cycles -> exactly one bit flip. Assert RST_N low mid-playback for 1 cycle -> leds = 0, playing = 0, frame_count = 0 asynchronously.
- With ANIMATION_RECORDER_CURSOR_BLINK_EN, buf = 0, cursor = 2, then 4 ani_tick pulses -> leds alternates 10'b0000000100 / 0 on each tick; without the macro, leds stays 0.
